pulse_rate_meter: RTL

- Consumes the synchronized event signal produced by the async-to-CLK pulse synchronizer and measures event rate: counts rising edges of that signal over a fixed gate window of CLK cycles.
- Holds the last completed count for software readout through a valid/ack handshake.
- Sits between the synchronizer and the Nios-facing register slave; it is the rate/frequency measurement engine for external asynchronous inputs.

---
 rtl/pulse_rate_meter.sv | 119 +++++++++++
 1 files changed

// File: rtl/pulse_rate_meter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_rate_meter
// Purpose  : Counts rising edges of a synchronized event over a fixed gate
//            window and holds the last result behind a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_rate_meter #(
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_W      = $clog2(GATE_CYCLES)
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             en,
    input  logic             sync_pulse,
    input  logic             rd_ack,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             count_sat,
    output logic             overrun,
    output logic             busy
);

    localparam logic [0:0]        c_idle      = 1'b0;
    localparam logic [0:0]        c_measure   = 1'b1;
    localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic              r_prev;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_evt_cnt;
    logic              r_sat;

    logic              w_run;
    logic              w_win_end;
    logic              w_edge;
    logic              w_at_max;
    logic [CNT_W-1:0]  w_evt_next;
    logic              w_sat_next;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dropping en in either state lands in IDLE; there is no other exit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:    w_next_state = en ? c_measure : c_idle;
            c_measure: w_next_state = en ? c_measure : c_idle;
            default:   w_next_state = c_idle;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        w_run     = 1'b0;
        w_win_end = 1'b0;
        if (r_state == c_measure) begin
            busy      = 1'b1;
            w_run     = en;
            w_win_end = en && (r_gate_cnt == c_gate_last);
        end
    end

    assign w_edge     = sync_pulse & ~r_prev;
    assign w_at_max   = (r_evt_cnt == c_cnt_max);
    assign w_evt_next = (w_edge && !w_at_max) ? r_evt_cnt + 1'b1 : r_evt_cnt;
    assign w_sat_next = r_sat | (w_edge & w_at_max);

    // Window end and abort both clear the counters; the next window starts
    // on the following cycle with no dead time.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_prev     <= 1'b0;
            r_gate_cnt <= '0;
            r_evt_cnt  <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_prev <= sync_pulse;
            if (w_run && !w_win_end) begin
                r_gate_cnt <= r_gate_cnt + 1'b1;
                r_evt_cnt  <= w_evt_next;
                r_sat      <= w_sat_next;
            end else begin
                r_gate_cnt <= '0;
                r_evt_cnt  <= '0;
                r_sat      <= 1'b0;
            end
        end
    end

    // A new result always wins over a simultaneous acknowledge.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            count_out   <= '0;
            count_sat   <= 1'b0;
            count_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (w_win_end) begin
            count_out   <= w_evt_next;
            count_sat   <= w_sat_next;
            count_valid <= 1'b1;
            overrun     <= ~rd_ack & (overrun | count_valid);
        end else if (rd_ack) begin
            count_valid <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule
`default_nettype wire
